muldiv_fu: RTL



---
 rtl/muldiv_fu.sv | 119 +++++++++++
 1 files changed

// File: rtl/muldiv_fu.sv
// muldiv_fu: iterative unsigned multiply/divide unit with a single-cycle CDB broadcast
package muldiv_pkg;
  localparam int WORD_SIZE_P = 16;
  localparam int OPC_W = 4;
  localparam int TAG_W = 5;
  localparam int ROB_W = 5;
  localparam int CDB_DEST_W = 6;
  typedef struct packed {
    logic [OPC_W-1:0]       opcode;
    logic [WORD_SIZE_P-1:0] source_1_data;
    logic [WORD_SIZE_P-1:0] source2_imm_data;
    logic [TAG_W-1:0]       dest_id;
    logic [ROB_W-1:0]       rob_dest;
  } issued_instruction_t;
  typedef struct packed {
    logic                   valid;
    logic [CDB_DEST_W-1:0]  dest;
    logic [WORD_SIZE_P-1:0] result;
    logic [ROB_W-1:0]       rob_dest;
    logic                   exception;
  } CDB_t;
endpackage

module muldiv_fu
  import muldiv_pkg::*;
#(
  parameter int WIDTH_P = WORD_SIZE_P,
  parameter logic [OPC_W-1:0] OPC_MUL_P = 4'd0,
  parameter logic [OPC_W-1:0] OPC_DIVU_P = 4'd1,
  parameter logic [OPC_W-1:0] OPC_REMU_P = 4'd2
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  issued_instruction_t instruction_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic                flush_i,
  output CDB_t                cdb_o
);
  localparam int CW = $clog2(WIDTH_P);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t               state_q;
  logic [OPC_W-1:0]     opc_q;
  logic [WIDTH_P-1:0]   b_q, quo_q, quo_d, res_d;
  logic [2*WIDTH_P-1:0] acc_q, acc_d, mcand_q;
  logic [WIDTH_P:0]     rem_q, rem_d;
  logic [WIDTH_P+1:0]   rem_sh;
  logic                 sub_ok;
  logic [CW-1:0]        cnt_q;
  logic [TAG_W-1:0]     dest_q;
  logic [ROB_W-1:0]     rob_q;
  CDB_t                 cdb_q;
  assign ready_o = (state_q == IDLE);
  assign cdb_o = (cdb_q.valid && !flush_i) ? cdb_q : '0;
  // one shift-add step and one restoring-division step, evaluated every BUSY cycle
  always_comb begin
    acc_d = acc_q + (b_q[cnt_q] ? mcand_q : '0);
    rem_sh = {rem_q, quo_q[WIDTH_P-1]};
    sub_ok = rem_sh >= {2'b00, b_q};
    rem_d = sub_ok ? (WIDTH_P+1)'(rem_sh - {2'b00, b_q}) : (WIDTH_P+1)'(rem_sh);
    quo_d = {quo_q[WIDTH_P-2:0], sub_ok};
    res_d = (opc_q == OPC_MUL_P)  ? acc_d[WIDTH_P-1:0] :
            (opc_q == OPC_DIVU_P) ? quo_d :
            (opc_q == OPC_REMU_P) ? rem_d[WIDTH_P-1:0] : '0;
  end
  // control FSM and datapath registers; flush aborts without broadcasting
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      opc_q   <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      dest_q  <= '0;
      rob_q   <= '0;
      cdb_q   <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
      cdb_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cdb_q <= '0;
          if (valid_i) begin
            state_q <= BUSY;
            opc_q   <= instruction_i.opcode;
            b_q     <= instruction_i.source2_imm_data[WIDTH_P-1:0];
            mcand_q <= {{WIDTH_P{1'b0}}, instruction_i.source_1_data[WIDTH_P-1:0]};
            quo_q   <= instruction_i.source_1_data[WIDTH_P-1:0];
            acc_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            dest_q  <= instruction_i.dest_id;
            rob_q   <= instruction_i.rob_dest;
          end
        end
        BUSY: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_q << 1;
          rem_q   <= rem_d;
          quo_q   <= quo_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH_P-1)) begin
            state_q <= DONE;
            cdb_q   <= '{valid: 1'b1, dest: CDB_DEST_W'(dest_q), result: WORD_SIZE_P'(res_d),
                         rob_dest: rob_q, exception: 1'b0};
          end
        end
        default: begin
          state_q <= IDLE;
          cdb_q   <= '0;
        end
      endcase
    end
  end
endmodule
